// File: rtl/dm_responder.sv
// Data-memory responder: accepts one CPU load/store at a time, waits WAIT_CYCLES,
// performs the byte/half/word access on a little-endian word store, then holds the response.
module dm_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sext,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  // Handshakes: a request transfers on a rising edge where req_valid & req_ready;
  // a response transfers on a rising edge where rsp_valid & rsp_ready. Payloads are
  // sampled only on those edges and held stable by the sender until the transfer.

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        alive;
  logic        accept;
  logic        do_access;

  logic        lat_we;
  logic [1:0]  lat_size;
  logic        lat_sext;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] mem_word;
  logic [31:0] byte_sh;
  logic [31:0] half_sh;
  logic [31:0] load_val;
  logic [31:0] store_data;
  logic [3:0]  byte_en;
  logic        illegal;
  logic        wr_en;

  // alive keeps req_ready low while reset is held, even though state is already IDLE.
  assign req_ready = (state == S_IDLE) && alive;
  assign rsp_valid = (state == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign dbg_state = state;

  assign accept    = req_valid && req_ready;
  assign do_access = (state == S_BUSY) && (cnt == 4'd0);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = S_BUSY;
          cnt_next   = 4'(WAIT_CYCLES);
        end
      end
      S_BUSY: begin
        if (cnt != 4'd0) begin
          cnt_next = cnt - 4'd1;
        end else begin
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      alive <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      alive <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_we    <= 1'b0;
      lat_size  <= 2'b00;
      lat_sext  <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
    end else if (accept) begin
      lat_we    <= req_we;
      lat_size  <= req_size;
      lat_sext  <= req_sext;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
  end

  // Alignment, size and range checks on the latched request.
  always_comb begin
    illegal = 1'b0;
    case (lat_size)
      2'b00:   illegal = 1'b0;
      2'b01:   illegal = lat_addr[0];
      2'b10:   illegal = (lat_addr[1:0] != 2'b00);
      default: illegal = 1'b1;
    endcase
    if ({2'b00, lat_addr[31:2]} >= DEPTH_W) begin
      illegal = 1'b1;
    end
  end

  assign mem_word = mem[lat_addr[AW+1:2]];
  assign byte_sh  = mem_word >> {lat_addr[1:0], 3'b000};
  assign half_sh  = mem_word >> {lat_addr[1], 4'b0000};

  always_comb begin
    load_val   = 32'd0;
    store_data = lat_wdata;
    byte_en    = 4'b0000;
    case (lat_size)
      2'b00: begin
        load_val   = lat_sext ? {{24{byte_sh[7]}}, byte_sh[7:0]} : {24'd0, byte_sh[7:0]};
        store_data = {4{lat_wdata[7:0]}};
        byte_en    = 4'b0001 << lat_addr[1:0];
      end
      2'b01: begin
        load_val   = lat_sext ? {{16{half_sh[15]}}, half_sh[15:0]} : {16'd0, half_sh[15:0]};
        store_data = {2{lat_wdata[15:0]}};
        byte_en    = lat_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        load_val   = mem_word;
        store_data = lat_wdata;
        byte_en    = 4'b1111;
      end
      default: begin
        load_val   = 32'd0;
        store_data = lat_wdata;
        byte_en    = 4'b0000;
      end
    endcase
  end

  // do_access is only true in BUSY, so an asserted reset can never write.
  assign wr_en = do_access && lat_we && !illegal;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[lat_addr[AW+1:2]][8*b +: 8] <= store_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (do_access) begin
      err_q   <= illegal;
      rdata_q <= (illegal || lat_we) ? 32'd0 : load_val;
    end else if ((state == S_RESP) && rsp_ready) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: one instance with WAIT_CYCLES=2 for the functional
// scenarios and one with WAIT_CYCLES=0 for back-to-back throughput.
module tb_dm_responder;

  logic        clk;
  logic        reset;

  logic        req_valid, req_ready, req_we, req_sext;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  dbg_state;

  logic        req_valid_b, req_ready_b, req_we_b, req_sext_b;
  logic [1:0]  req_size_b;
  logic [31:0] req_addr_b, req_wdata_b;
  logic        rsp_valid_b, rsp_ready_b, rsp_err_b;
  logic [31:0] rsp_rdata_b;
  logic [1:0]  dbg_state_b;

  int vectors;
  int miscompares;
  int cyc;

  dm_responder #(.WAIT_CYCLES(2), .DEPTH_WORDS(1024)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  dm_responder #(.WAIT_CYCLES(0), .DEPTH_WORDS(1024)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
    .req_size(req_size_b), .req_sext(req_sext_b), .req_addr(req_addr_b),
    .req_wdata(req_wdata_b), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
    .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b), .dbg_state(dbg_state_b)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Driver: one request on dut, returns response payload and accept-to-valid edge count.
  task automatic do_a(input logic we, input logic [1:0] size, input logic sext,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output int lat);
    int n;
    n = 0;
    rdata = 32'hxxxx_xxxx;
    err = 1'bx;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      vectors++; miscompares++;
      $display("FAIL req_ready_timeout got=%b want=1", req_ready);
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_sext = sext;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = $urandom_range(0, 1) == 1;
    req_size = 2'($urandom_range(0, 3)); req_sext = $urandom_range(0, 1) == 1;
    req_addr = $urandom; req_wdata = $urandom;
    lat = 0;
    @(negedge clk);
    while (!rsp_valid && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!rsp_valid) begin
      vectors++; miscompares++;
      $display("FAIL rsp_valid_timeout got=%b want=1", rsp_valid);
    end
    rdata = rsp_rdata;
    err = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata, dbg_state} !== 36'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%h want=0", {req_ready, rsp_valid, rsp_err, rsp_rdata, dbg_state});
    end
    vectors++;
    repeat (2) @(negedge clk);
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_held_ready got=%b want=0", req_ready);
    end
    vectors++;
    reset = 1'b1;
    @(negedge clk);
    if (req_ready !== 1'b1 || dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_release got=%b/%0d want=1/0", req_ready, dbg_state);
    end
    vectors++;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    do_a(1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, rd, er, lat);
    if (lat !== 3 || er !== 1'b0 || rd !== 32'd0) begin
      miscompares++;
      $display("FAIL store_word lat=%0d err=%b rd=%h want 3/0/0", lat, er, rd);
    end
    vectors++;
    do_a(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    if (rd !== 32'h1234_5678 || er !== 1'b0 || lat !== 3) begin
      miscompares++;
      $display("FAIL load_word got=%h err=%b lat=%0d want=12345678/0/3", rd, er, lat);
    end
    vectors++;
  endtask

  task automatic test_subword();
    logic        t_we  [12] = '{1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
    logic [1:0]  t_sz  [12] = '{2, 0, 0, 0, 2, 2, 1, 0, 2, 1, 1, 0};
    logic        t_sx  [12] = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    logic [31:0] t_ad  [12] = '{32'h10, 32'h11, 32'h11, 32'h11, 32'h10, 32'h14, 32'h16, 32'h17,
                               32'h14, 32'h16, 32'h16, 32'h14};
    logic [31:0] t_wd  [12] = '{32'h0, 32'hFFFF_FF80, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1234_BEEF,
                               32'hFFFF_FFAB, 32'h0, 32'h0, 32'h0, 32'h5555_5511};
    logic [31:0] t_exp [12] = '{32'h0, 32'h0, 32'hFFFF_FF80, 32'h0000_0080, 32'h0000_8000, 32'h0,
                               32'h0, 32'h0, 32'hABEF_0000, 32'hFFFF_ABEF, 32'h0000_ABEF, 32'h0};
    logic [31:0] rd; logic er; int lat;
    for (int i = 0; i < 12; i++) begin
      do_a(t_we[i], t_sz[i], t_sx[i], t_ad[i], t_wd[i], rd, er, lat);
      if (rd !== t_exp[i] || er !== 1'b0) begin
        miscompares++;
        $display("FAIL subword[%0d] got=%h err=%b want=%h/0", i, rd, er, t_exp[i]);
      end
      vectors++;
    end
    do_a(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, rd, er, lat);
    if (rd !== 32'hABEF_0011) begin
      miscompares++;
      $display("FAIL byte_lane0 got=%h want=abef0011", rd);
    end
    vectors++;
  endtask

  task automatic test_errors();
    logic        t_we [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    logic [1:0]  t_sz [8] = '{1, 2, 3, 2, 1, 2, 3, 2};
    logic [31:0] t_ad [8] = '{32'h13, 32'h12, 32'h0, 32'h1000, 32'h13, 32'h12, 32'h0, 32'h1000};
    logic [31:0] rd; logic er; int lat;
    do_a(1'b1, 2'b10, 1'b0, 32'h0, 32'hCAFE_F00D, rd, er, lat);
    do_a(1'b1, 2'b10, 1'b0, 32'hFFC, 32'h55AA_55AA, rd, er, lat);
    for (int i = 0; i < 8; i++) begin
      do_a(t_we[i], t_sz[i], 1'b1, t_ad[i], 32'hFFFF_FFFF, rd, er, lat);
      if (er !== 1'b1 || rd !== 32'd0) begin
        miscompares++;
        $display("FAIL error[%0d] err=%b rd=%h want=1/0", i, er, rd);
      end
      vectors++;
    end
    do_a(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    if (rd !== 32'h0000_8000) begin
      miscompares++;
      $display("FAIL err_nowrite_10 got=%h want=00008000", rd);
    end
    vectors++;
    do_a(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, er, lat);
    if (rd !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("FAIL err_nowrite_0 got=%h want=cafef00d", rd);
    end
    vectors++;
    do_a(1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, rd, er, lat);
    if (rd !== 32'h55AA_55AA || er !== 1'b0) begin
      miscompares++;
      $display("FAIL last_word got=%h err=%b want=55aa55aa/0", rd, er);
    end
    vectors++;
  endtask

  task automatic test_hold();
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_sext = 1'b0; req_addr = 32'h10;
    @(posedge clk);
    #1 req_we = 1'b1; req_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_8000 || req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL hold[%0d] v=%b rd=%h rdy=%b want 1/00008000/0", i, rsp_valid, rsp_rdata, req_ready);
      end
      vectors++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_release v=%b rdy=%b want 0/1", rsp_valid, req_ready);
    end
    vectors++;
  endtask

  task automatic test_reset_busy();
    logic [31:0] rd; logic er; int lat;
    do_a(1'b1, 2'b10, 1'b0, 32'h20, 32'h0102_0304, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    if (dbg_state !== 2'd1) begin
      miscompares++;
      $display("FAIL busy_state got=%0d want=1", dbg_state);
    end
    vectors++;
    reset = 1'b0;
    #1;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata, dbg_state} !== 36'd0) begin
      miscompares++;
      $display("FAIL busy_reset got=%h want=0", {req_ready, rsp_valid, rsp_err, rsp_rdata, dbg_state});
    end
    vectors++;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    do_a(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat);
    if (rd !== 32'h0102_0304) begin
      miscompares++;
      $display("FAIL reset_nowrite got=%h want=01020304", rd);
    end
    vectors++;
    do_a(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    if (rd !== 32'h0000_8000) begin
      miscompares++;
      $display("FAIL reset_keeps_mem got=%h want=00008000", rd);
    end
    vectors++;
  endtask

  task automatic test_back_to_back();
    logic        t_we  [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    logic [31:0] t_ad  [8] = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h4C, 32'h48, 32'h44, 32'h40};
    logic [31:0] t_wd  [8] = '{32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003, 32'hA5A5_0004,
                              32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] t_exp [8] = '{32'h0, 32'h0, 32'h0, 32'h0,
                              32'hA5A5_0004, 32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001};
    int prev, n;
    prev = 0;
    rsp_ready_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      @(negedge clk);
      while (!req_ready_b && n < 20) begin
        @(negedge clk);
        n++;
      end
      req_valid_b = 1'b1; req_we_b = t_we[i]; req_size_b = 2'b10; req_sext_b = 1'b0;
      req_addr_b = t_ad[i]; req_wdata_b = t_wd[i];
      @(posedge clk);
      n = 0;
      @(negedge clk);
      while (!rsp_valid_b && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (rsp_valid_b !== 1'b1 || rsp_rdata_b !== t_exp[i] || rsp_err_b !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_data[%0d] v=%b rd=%h err=%b want 1/%h/0", i, rsp_valid_b, rsp_rdata_b, rsp_err_b, t_exp[i]);
      end
      vectors++;
      if (i > 0) begin
        if (cyc - prev !== 3) begin
          miscompares++;
          $display("FAIL b2b_period[%0d] got=%0d want=3", i, cyc - prev);
        end
        vectors++;
      end
      prev = cyc;
    end
    req_valid_b = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_sext = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    req_valid_b = 1'b0; req_we_b = 1'b0; req_size_b = 2'b00; req_sext_b = 1'b0;
    req_addr_b = 32'd0; req_wdata_b = 32'd0; rsp_ready_b = 1'b0;
    test_reset();
    test_word();
    test_subword();
    test_errors();
    test_hold();
    test_reset_busy();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
